// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: load-use stall, MEM redirect flush and halt/drain FSM.
// Define PIPELINE_CTRL_PERF_CNT_EN to build the saturating stall/flush performance counters.
module pipeline_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             enable,
    input  logic             halt_req,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             exe_mem_read,
    input  logic [4:0]       exe_waddr,
    input  logic             mem_redirect,
    output logic [4:0]       stage_en,
    output logic             bubble,
    output logic             flush,
    output logic [1:0]       state,
    output logic             done,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t     state_r;
    logic [3:0] drain_cnt_r;
    logic       hazard_s;
    logic [4:0] stage_en_s;
    logic       bubble_s;
    logic       flush_s;
    logic       done_s;

    // Load-use hazard between the EXE load and the ID operands; r0 never hazards.
    always_comb begin
        hazard_s = exe_mem_read && (exe_waddr != 5'd0) &&
                   ((exe_waddr == id_rs) || (id_uses_rt && (exe_waddr == id_rt)));
    end

    // Stage controls decoded from the current state; reset and freeze force everything idle.
    always_comb begin
        stage_en_s = 5'b00000;
        bubble_s   = 1'b0;
        flush_s    = 1'b0;
        done_s     = 1'b0;
        if (!arst_n || !enable) begin
            stage_en_s = 5'b00000;
        end else begin
            case (state_r)
                IDLE: stage_en_s = 5'b00000;
                RUN: begin
                    if (mem_redirect) begin
                        stage_en_s = 5'b11111;
                        flush_s    = 1'b1;
                    end else if (hazard_s) begin
                        stage_en_s = 5'b00111;
                        bubble_s   = 1'b1;
                    end else begin
                        stage_en_s = 5'b11111;
                    end
                end
                DRAIN: begin
                    // A redirect still has to squash wrong-path work while draining.
                    if (mem_redirect) begin
                        stage_en_s = 5'b11111;
                        flush_s    = 1'b1;
                    end else begin
                        stage_en_s = 5'b01111;
                        bubble_s   = 1'b1;
                    end
                end
                DONE:    done_s     = 1'b1;
                default: stage_en_s = 5'b00000;
            endcase
        end
    end

    // Halt/drain FSM; a frozen cycle holds both state and drain counter.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_r     <= IDLE;
            drain_cnt_r <= 4'd0;
        end else if (enable) begin
            case (state_r)
                IDLE: begin
                    if (!halt_req) state_r <= RUN;
                end
                RUN: begin
                    if (halt_req) begin
                        state_r     <= DRAIN;
                        drain_cnt_r <= DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_r == 4'd0) begin
                        state_r <= DONE;
                    end else begin
                        drain_cnt_r <= drain_cnt_r - 4'd1;
                    end
                end
                DONE:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

`ifdef PIPELINE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // Saturating event counters; drain bubbles are not load-use stalls.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (bubble_s && (state_r == RUN) && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end
            if (flush_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`else
    assign stall_cnt = {CNT_W{1'b0}};
    assign flush_cnt = {CNT_W{1'b0}};
`endif

    assign stage_en = stage_en_s;
    assign bubble   = bubble_s;
    assign flush    = flush_s;
    assign done     = done_s;
    assign state    = state_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: expected controls are queued per cycle and
// compared against the DUT half a clock later.
module tb_pipeline_ctrl;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             arst_n = 1'b0;
    logic             enable = 1'b0;
    logic             halt_req = 1'b0;
    logic [4:0]       id_rs = 5'd0;
    logic [4:0]       id_rt = 5'd0;
    logic             id_uses_rt = 1'b0;
    logic             exe_mem_read = 1'b0;
    logic [4:0]       exe_waddr = 5'd0;
    logic             mem_redirect = 1'b0;
    logic [4:0]       stage_en;
    logic             bubble;
    logic             flush;
    logic [1:0]       state;
    logic             done;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    typedef struct {
        logic [4:0]       se;
        logic             b;
        logic             f;
        logic [1:0]       st;
        logic             d;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    exp_t             sb_q[$];
    int               n_checks = 0;
    int               n_pass = 0;
    logic [CNT_W-1:0] m_stall = '0;
    logic [CNT_W-1:0] m_flush = '0;

    pipeline_ctrl #(.DRAIN_CYCLES(4), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .enable       (enable),
        .halt_req     (halt_req),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .exe_mem_read (exe_mem_read),
        .exe_waddr    (exe_waddr),
        .mem_redirect (mem_redirect),
        .stage_en     (stage_en),
        .bubble       (bubble),
        .flush        (flush),
        .state        (state),
        .done         (done),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic set_ops(input logic mr, input logic [4:0] wa, input logic [4:0] rs,
                           input logic [4:0] rt, input logic urt, input logic redir);
        exe_mem_read = mr;
        exe_waddr    = wa;
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rt   = urt;
        mem_redirect = redir;
    endtask

    // One cycle: drive after the edge, queue the expectation, compare on the falling edge.
    task automatic cyc(input logic rst_v, input logic en_v, input logic halt_v,
                       input logic [4:0] se, input logic b, input logic f,
                       input logic [1:0] st, input logic d, input string tag);
        exp_t e;
        exp_t o;
        @(posedge clk);
        #1;
        arst_n   = rst_v;
        enable   = en_v;
        halt_req = halt_v;
        e.se = se; e.b = b; e.f = f; e.st = st; e.d = d;
        e.sc = m_stall; e.fc = m_flush;
        sb_q.push_back(e);
        @(negedge clk);
        o = sb_q.pop_front();
        check_eq({tag, ".stage_en"},  32'(stage_en),  32'(o.se));
        check_eq({tag, ".bubble"},    32'(bubble),    32'(o.b));
        check_eq({tag, ".flush"},     32'(flush),     32'(o.f));
        check_eq({tag, ".state"},     32'(state),     32'(o.st));
        check_eq({tag, ".done"},      32'(done),      32'(o.d));
        check_eq({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(o.sc));
        check_eq({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(o.fc));
        if (!rst_v) begin
            m_stall = '0;
            m_flush = '0;
        end else begin
`ifdef PIPELINE_CTRL_PERF_CNT_EN
            if (b && (st == 2'b01)) m_stall = m_stall + 16'd1;
            if (f) m_flush = m_flush + 16'd1;
`endif
        end
    endtask

    initial begin
        // Reset and start-up.
        cyc(1'b0, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 2'b00, 1'b0, "rst");
        cyc(1'b1, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 2'b00, 1'b0, "idle");
        cyc(1'b1, 1'b1, 1'b0, 5'b11111, 1'b0, 1'b0, 2'b01, 1'b0, "run");
        // Load-use on rs, then cleared.
        set_ops(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 5'b00111, 1'b1, 1'b0, 2'b01, 1'b0, "haz_rs");
        set_ops(1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 5'b11111, 1'b0, 1'b0, 2'b01, 1'b0, "after_haz");
        // Destination r0 never stalls.
        set_ops(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 5'b11111, 1'b0, 1'b0, 2'b01, 1'b0, "r0");
        // rt hazard only when rt is read.
        set_ops(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 5'b00111, 1'b1, 1'b0, 2'b01, 1'b0, "haz_rt");
        set_ops(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 5'b11111, 1'b0, 1'b0, 2'b01, 1'b0, "rt_unused");
        // Redirect beats stall.
        set_ops(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 5'b11111, 1'b0, 1'b1, 2'b01, 1'b0, "flush_prio");
        set_ops(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 5'b11111, 1'b0, 1'b0, 2'b01, 1'b0, "after_flush");
        // Freeze in RUN with a pending hazard.
        set_ops(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 2'b01, 1'b0, "freeze_run");
        set_ops(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        // Halt and drain: 4 enabled DRAIN cycles, one frozen cycle, one redirect.
        cyc(1'b1, 1'b1, 1'b1, 5'b11111, 1'b0, 1'b0, 2'b01, 1'b0, "halt");
        cyc(1'b1, 1'b1, 1'b0, 5'b01111, 1'b1, 1'b0, 2'b10, 1'b0, "drain1");
        cyc(1'b1, 1'b1, 1'b0, 5'b01111, 1'b1, 1'b0, 2'b10, 1'b0, "drain2");
        cyc(1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 2'b10, 1'b0, "drain_frz");
        set_ops(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 5'b11111, 1'b0, 1'b1, 2'b10, 1'b0, "drain3_flush");
        set_ops(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 5'b01111, 1'b1, 1'b0, 2'b10, 1'b0, "drain4");
        cyc(1'b1, 1'b1, 1'b1, 5'b00000, 1'b0, 1'b0, 2'b11, 1'b1, "done");
        cyc(1'b1, 1'b1, 1'b1, 5'b00000, 1'b0, 1'b0, 2'b00, 1'b0, "idle_wait1");
        cyc(1'b1, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 2'b00, 1'b0, "idle_wait2");
        cyc(1'b1, 1'b1, 1'b0, 5'b11111, 1'b0, 1'b0, 2'b01, 1'b0, "rerun");
        // Reset during the second DRAIN cycle.
        cyc(1'b1, 1'b1, 1'b1, 5'b11111, 1'b0, 1'b0, 2'b01, 1'b0, "halt2");
        cyc(1'b1, 1'b1, 1'b0, 5'b01111, 1'b1, 1'b0, 2'b10, 1'b0, "d2_1");
        cyc(1'b0, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 2'b10, 1'b0, "d2_rst");
        cyc(1'b1, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 2'b00, 1'b0, "post_rst");
        cyc(1'b1, 1'b1, 1'b0, 5'b11111, 1'b0, 1'b0, 2'b01, 1'b0, "run_again");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 4; number of cycles held in DRAIN before IDLE, legal range 1..15.
REQ-002 SHALL have parameter CNT_W, default 16; width of the performance counters.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port arst_n  in  1  reset; it is synchronous and active-low, sampled on the rising edge of clk.
REQ-005 SHALL have port enable  in  1  run/freeze; 0 freezes the whole pipeline.
REQ-006 SHALL have port halt_req  in  1  level request to drain the pipeline and stop.
REQ-007 SHALL have port id_rs  in  5  rs field of the instruction in ID.
REQ-008 SHALL have port id_rt  in  5  rt field of the instruction in ID.
REQ-009 SHALL have port id_uses_rt  in  1  the ID instruction reads rt.
REQ-010 SHALL have port exe_mem_read  in  1  the EXE instruction is a load.
REQ-011 SHALL have port exe_waddr  in  5  destination register of the EXE instruction.
REQ-012 SHALL have port mem_redirect  in  1  taken branch or jump resolved in MEM.
REQ-013 SHALL have port stage_en  out  5  stage enables {pc, IF/ID, ID/EXE, EXE/MEM, MEM/WB} in bits [4:0].
REQ-014 SHALL have port bubble  out  1  force zero control into ID/EXE.
REQ-015 SHALL have port flush  out  1  zero IF/ID instruction and ID/EXE plus EXE/MEM control.
REQ-016 SHALL have port state  out  2  FSM state: IDLE=00, RUN=01, DRAIN=10, DONE=11.
REQ-017 SHALL have port done  out  1  one-cycle pulse when the drain completes.
REQ-018 SHALL have port stall_cnt  out  CNT_W  load-use stall cycles.
REQ-019 SHALL have port flush_cnt  out  CNT_W  flush cycles.

Function
REQ-020 SHALL define hazard = exe_mem_read & (exe_waddr!=0) & ((exe_waddr==id_rs) | (id_uses_rt & exe_waddr==id_rt)); all outputs other than the counters are combinational from the registered state and the inputs.
REQ-021 In IDLE, SHALL drive stage_en=00000, bubble=0 and flush=0, and go to RUN on the next edge when enable=1 and halt_req=0.
REQ-022 In RUN with no event, SHALL drive stage_en=11111.
REQ-023 In RUN with hazard=1 and mem_redirect=0, SHALL drive stage_en=00111 and bubble=1 for exactly that cycle; the stall is one cycle because the load advances to MEM.
REQ-024 In RUN or DRAIN, mem_redirect=1 SHALL drive flush=1 and stage_en=11111, with bubble=0 and the hazard ignored; flush has priority over stall.
REQ-025 In RUN with halt_req=1, SHALL go to DRAIN and load the drain counter with DRAIN_CYCLES-1.
REQ-026 In DRAIN, SHALL drive stage_en=01111 and bubble=1, decrement the counter each enabled cycle, and go to DONE when it reads 0.
REQ-027 In DONE, SHALL drive stage_en=00000 and done=1 for one cycle, then go to IDLE; IDLE SHALL then wait for halt_req=0.
REQ-028 enable=0 in any state SHALL force stage_en=00000, bubble=0, flush=0 and done=0, and SHALL hold the state and drain counter.
REQ-029 A halt_req deasserted during DRAIN SHALL NOT abort the drain.

Reset
REQ-030 arst_n=0 at a clock edge SHALL set state=IDLE, drain counter=0, stall_cnt=0 and flush_cnt=0, including when the reset arrives mid-DRAIN or mid-stall.
REQ-031 While arst_n=0, SHALL drive stage_en=00000, bubble=0, flush=0 and done=0.

Configuration
REQ-032 With macro PIPELINE_CTRL_PERF_CNT_EN defined, stall_cnt SHALL increment on each cycle with bubble=1 in RUN, and flush_cnt SHALL increment on each cycle with flush=1; both SHALL saturate at all-ones.
REQ-033 Without PIPELINE_CTRL_PERF_CNT_EN, stall_cnt and flush_cnt SHALL be constant 0 and no counter registers SHALL be built.

Verification
REQ-034 Reset then enable=1 -> state=01 one cycle later and stage_en=11111.
REQ-035 RUN, exe_mem_read=1, exe_waddr=5, id_rs=5 -> stage_en=00111 and bubble=1 for 1 cycle; stall_cnt=1 with the macro, 0 without.
REQ-036 Same as REQ-035 but exe_waddr=0 -> no stall, stage_en=11111.
REQ-037 Hazard and mem_redirect=1 in the same cycle -> flush=1, bubble=0, stage_en=11111; flush_cnt=1.
REQ-038 halt_req=1 in RUN with DRAIN_CYCLES=4 -> 4 cycles in DRAIN with stage_en=01111, then done=1 for one cycle, then state=00.
REQ-039 arst_n=0 during the second DRAIN cycle -> state=00 at the next edge and counters=0; enable=0 during DRAIN -> state held and stage_en=00000.
